mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between two requesters: instruction fetch (IF) and the memory stage (M).
- Arbitrates between them, sequences each access with a req/ack handshake, and returns read data.
- Generates the stall signals the pipeline uses to freeze the IF and M stages while they wait.
- Includes a starvation guard for fetch and a stuck-memory timeout.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants while if_req is pending; after this many, fetch is forced.
- TIMEOUT, 255: cycles a granted access may wait for mem_ack before it is aborted as a bus error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (block is in reset while rst==0).
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  32  fetch byte address; stable while if_req is high.
- if_rdata  out  32  fetched instruction; valid while if_ready is high.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; level, held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_funct3  in  3  RISC-V access size/sign code, passed through to memory.
- dm_rdata  out  32  load data; valid while dm_ready is high; 0 for stores.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_funct3  out  3  memory size code.
- mem_rdata  in  32  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory completion; one cycle.
- stall_if  out  1  IF stage must hold.
- stall_m  out  1  M stage must hold.
- bus_error  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-access drops mem_req immediately and abandons the access with no ready pulse; the memory must tolerate an abandoned request.
- States: IDLE, FETCH, DATA, RESP.
- IDLE arbitration, in order:
  - dm_req && !(if_req && starve_cnt==STARVE_LIMIT) -> DATA.
  - else if_req -> FETCH.
  - else stay in IDLE.
- Grant capture: the granted request's addr/we/wdata/funct3 are latched into registers on the grant edge. mem_* are driven only from these registers; fetch drives mem_we=0 and mem_funct3=3'd2.
- FETCH/DATA:
  - mem_req=1 in every cycle of the state.
  - On mem_ack: latch mem_rdata, clear wait_cnt, go to RESP.
  - Otherwise wait_cnt increments. When wait_cnt==TIMEOUT-1 with no ack, go to RESP with rdata=0 and set bus_error.
- RESP: the ready of the served requester is 1 for exactly this cycle, with rdata driven from the latched value; next state is always IDLE.
- Latency: minimum 3 cycles from request to ready with a zero-wait memory (req seen at cycle 0 -> mem_req and ack at cycle 1 -> ready at cycle 2). Accesses never overlap.
- Handshake: a requester whose req is still high in the cycle after its ready pulse is making a new transaction; the arbiter only samples req in IDLE.
- dm_rdata=0 for stores.
- starve_cnt, updated on each IDLE grant edge:
  - DATA grant with if_req=1: increment, saturating at STARVE_LIMIT.
  - DATA grant with if_req=0: clear.
  - FETCH grant: clear.
- stall_if = if_req & ~if_ready; stall_m = dm_req & ~dm_ready. Both combinational.
- mem_ack in IDLE or RESP is ignored.
- A request change while not granted is harmless; a request change while granted is a protocol violation whose result is undefined.
- bus_error clears only on reset.

Test Plan:
- Zero-wait fetch: if_req=1 with if_addr=0x10 at cycle 0, mem_ack tied high with mem_rdata=0x00500093 -> mem_req=1 and mem_addr=0x10 at cycle 1; if_ready=1 and if_rdata=0x00500093 at cycle 2; stall_if high at cycles 0-1, low at cycle 2.
- Simultaneous if_req and dm_req (load, addr 0x100) -> DATA granted first and dm_ready pulses; FETCH is granted on the next IDLE.
- Starvation: if_req held high, dm_req high continuously, STARVE_LIMIT=4 -> exactly 4 data grants, then one fetch grant, then data again.
- Store: dm_we=1, dm_wdata=0xDEADBEEF, dm_funct3=2, ack after 3 wait cycles -> mem_we=1 and mem_wdata=0xDEADBEEF throughout; dm_ready pulses once with dm_rdata=0.
- Timeout: TIMEOUT=8, mem_ack never asserted -> mem_req high for 8 cycles; if_ready=1 with if_rdata=0; bus_error=1 and it stays high through later successful accesses.
- Reset mid-access: rst=0 while in DATA -> mem_req=0 immediately with no dm_ready; after release, the same held dm_req is re-granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                                |
// | Function : Shares one variable-latency memory port between IF and M,       |
// |            with fetch starvation guard and stuck-memory timeout.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [2:0]  dm_funct3,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_m,
    output logic        bus_error
);

    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int c_WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX  = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE  = c_STARVE_W'(1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST   = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_ONE    = c_WAIT_W'(1);
    localparam logic [2:0]            c_FETCH_SIZE  = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_addr;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [2:0]            r_funct3;
    logic [31:0]           r_rdata;
    logic                  r_is_dm;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic                  r_bus_error;

    logic w_starved;
    logic w_grant_dm;
    logic w_grant_if;
    logic w_busy;
    logic w_timeout;

    always_comb begin
        w_starved  = if_req && (r_starve_cnt == c_STARVE_MAX);
        w_grant_dm = (r_state == IDLE) && dm_req && !w_starved;
        w_grant_if = (r_state == IDLE) && !w_grant_dm && if_req;
        w_busy     = (r_state == FETCH) || (r_state == DATA);
        w_timeout  = w_busy && !mem_ack && (r_wait_cnt == c_WAIT_LAST);
        w_next     = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_dm) begin
                    w_next = DATA;
                end else if (w_grant_if) begin
                    w_next = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ack || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_funct3     <= '0;
            r_rdata      <= '0;
            r_is_dm      <= 1'b0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_bus_error  <= 1'b0;
        end else begin
            if (w_grant_dm) begin
                r_addr   <= dm_addr;
                r_we     <= dm_we;
                r_wdata  <= dm_wdata;
                r_funct3 <= dm_funct3;
                r_is_dm  <= 1'b1;
                // Only data grants made while fetch waits count toward starvation.
                if (!if_req) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != c_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + c_STARVE_ONE;
                end
            end else if (w_grant_if) begin
                r_addr       <= if_addr;
                r_we         <= 1'b0;
                r_wdata      <= '0;
                r_funct3     <= c_FETCH_SIZE;
                r_is_dm      <= 1'b0;
                r_starve_cnt <= '0;
            end

            if (w_busy) begin
                if (mem_ack) begin
                    // Stores return zero so the M stage never sees stale bus data.
                    r_rdata    <= r_we ? 32'd0 : mem_rdata;
                    r_wait_cnt <= '0;
                end else if (w_timeout) begin
                    r_rdata     <= '0;
                    r_wait_cnt  <= '0;
                    r_bus_error <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + c_WAIT_ONE;
                end
            end
        end
    end

    assign mem_req    = w_busy;
    assign mem_we     = w_busy && r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_funct3 = r_funct3;

    assign if_ready   = (r_state == RESP) && !r_is_dm;
    assign dm_ready   = (r_state == RESP) && r_is_dm;
    assign if_rdata   = if_ready ? r_rdata : 32'd0;
    assign dm_rdata   = dm_ready ? r_rdata : 32'd0;

    assign stall_if   = if_req && !if_ready;
    assign stall_m    = dm_req && !dm_ready;
    assign bus_error  = r_bus_error;

endmodule
`default_nettype wire
